// File: rtl/hazard_controller_pkg.sv
// Shared types for the hazard controller: state encodings and opcode constants.
// Optional HAZARD_PERF_CNT_EN feature lives in hazard_controller.sv.
package hazard_controller_pkg;

    localparam int HZ_STATE_WIDTH = 2;

    typedef enum logic [HZ_STATE_WIDTH-1:0] {
        HZ_IDLE     = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_MEM_WAIT = 2'd2,
        HZ_FLUSH    = 2'd3
    } hz_state_e;

    localparam logic [6:0] LOAD_WORD  = 7'b0000011;
    localparam logic [6:0] STORE_WORD = 7'b0100011;

    function automatic logic hz_is_load(input logic [6:0] opcode);
        return opcode == LOAD_WORD;
    endfunction

    function automatic logic hz_is_store(input logic [6:0] opcode);
        return opcode == STORE_WORD;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: execute-stage load whose rd feeds a decode source.
module hazard_detect
    import hazard_controller_pkg::*;
#(
    parameter int AWIDTH = 5
) (
    input  logic              ex_ce,
    input  logic              ex_is_load,
    input  logic [AWIDTH-1:0] ex_rd,
    input  logic              id_ce,
    input  logic [AWIDTH-1:0] rs1,
    input  logic [AWIDTH-1:0] rs2,
    output logic              lu_hit
);

    logic rd_nz;
    logic rd_match;

    assign rd_nz    = |ex_rd;
    assign rd_match = (ex_rd == rs1) | (ex_rd == rs2);
    assign lu_hit   = ex_ce & ex_is_load & rd_nz & id_ce & rd_match;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, memory wait, redirect).
// Define HAZARD_PERF_CNT_EN to add stall-cycle and flush-event counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int AWIDTH       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CWIDTH       = 4
) (
    input  logic              hz_clk,
    input  logic              hz_rst,
    input  logic              hz_i_id_ce,
    input  logic [AWIDTH-1:0] hz_i_id_addr_rs1,
    input  logic [AWIDTH-1:0] hz_i_id_addr_rs2,
    input  logic              hz_i_ex_ce,
    input  logic              hz_i_ex_is_load,
    input  logic [AWIDTH-1:0] hz_i_ex_addr_rd,
    input  logic              hz_i_change_pc,
    input  logic              hz_i_mem_req,
    input  logic              hz_i_mem_ack,
    output logic              hz_o_stall_if,
    output logic              hz_o_stall_id,
    output logic              hz_o_stall_ex,
    output logic              hz_o_flush_id,
    output logic              hz_o_flush_ex,
    output logic              hz_o_timeout,
    output logic [1:0]        hz_o_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       hz_o_stall_cycles,
    output logic [15:0]       hz_o_flush_events
`endif
);

    localparam logic [CWIDTH-1:0] FLUSH_LOAD = CWIDTH'(FLUSH_CYCLES - 1);
    localparam logic [CWIDTH-1:0] TMO_LIMIT  = CWIDTH'(MEM_TIMEOUT);
    localparam logic [CWIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CWIDTH-1:0] CNT_ONE    = CWIDTH'(1);
    localparam hz_state_e FLUSH_NEXT =
        (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_IDLE;

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic [CWIDTH-1:0] cnt_q;
    logic [CWIDTH-1:0] cnt_d;
    logic              pend_q;
    logic              pend_d;
    logic              timeout_q;
    logic              timeout_d;

    logic lu_hit;
    logic mem_stall;
    logic tmo_now;
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic flush_id;
    logic flush_ex;

    hazard_detect #(
        .AWIDTH(AWIDTH)
    ) u_detect (
        .ex_ce      (hz_i_ex_ce),
        .ex_is_load (hz_i_ex_is_load),
        .ex_rd      (hz_i_ex_addr_rd),
        .id_ce      (hz_i_id_ce),
        .rs1        (hz_i_id_addr_rs1),
        .rs2        (hz_i_id_addr_rs2),
        .lu_hit     (lu_hit)
    );

    assign mem_stall = hz_i_mem_req & ~hz_i_mem_ack;

    always_ff @(posedge hz_clk or posedge hz_rst) begin
        if (hz_rst) begin
            state_q   <= HZ_IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        timeout_d = timeout_q;
        tmo_now   = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        unique case (state_q)
            HZ_IDLE, HZ_LOAD_USE: begin
                state_d = HZ_IDLE;
                if (hz_i_change_pc) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    state_d  = FLUSH_NEXT;
                    cnt_d    = FLUSH_LOAD;
                end else if (mem_stall) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    state_d  = HZ_MEM_WAIT;
                    cnt_d    = CNT_ONE;
                end else if (lu_hit) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                    state_d  = HZ_LOAD_USE;
                end
            end
            HZ_MEM_WAIT: begin
                if (hz_i_mem_ack) begin
                    pend_d = 1'b0;
                    // deferred redirect gets its front-end kill now
                    if (pend_q | hz_i_change_pc) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                        state_d  = FLUSH_NEXT;
                        cnt_d    = FLUSH_LOAD;
                    end else begin
                        state_d = HZ_IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == TMO_LIMIT) begin
                    tmo_now   = 1'b1;
                    timeout_d = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = HZ_IDLE;
                    cnt_d     = '0;
                end else begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    if (hz_i_change_pc) begin
                        pend_d = 1'b1;
                    end
                end
            end
            HZ_FLUSH: begin
                flush_id = 1'b1;
                if (hz_i_change_pc) begin
                    flush_ex = 1'b1;
                    state_d  = FLUSH_NEXT;
                    cnt_d    = FLUSH_LOAD;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = HZ_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = HZ_IDLE;
            end
        endcase
    end

    // outputs are forced quiet while reset is held
    assign hz_o_stall_if = stall_if & ~hz_rst;
    assign hz_o_stall_id = stall_id & ~hz_rst;
    assign hz_o_stall_ex = stall_ex & ~hz_rst;
    assign hz_o_flush_id = flush_id & ~hz_rst;
    assign hz_o_flush_ex = flush_ex & ~hz_rst;
    assign hz_o_timeout  = (timeout_q | tmo_now) & ~hz_rst;
    assign hz_o_state    = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_events_q;
    logic        any_stall;
    logic        pc_seen;

    assign any_stall = hz_o_stall_if | hz_o_stall_id | hz_o_stall_ex;
    assign pc_seen   = hz_i_change_pc & ~tmo_now;

    always_ff @(posedge hz_clk or posedge hz_rst) begin
        if (hz_rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (any_stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (pc_seen) begin
                flush_events_q <= flush_events_q + 16'd1;
            end
        end
    end

    assign hz_o_stall_cycles = stall_cycles_q;
    assign hz_o_flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed plan plus random traffic.
// A behavioural model pushes expected outputs; a negedge monitor compares.
module tb_hazard_controller;

    localparam int AW = 5;
    localparam int FC = 2;
    localparam int MT = 15;
    localparam int CW = 4;

    logic          hz_clk = 1'b0;
    logic          hz_rst = 1'b1;
    logic          hz_i_id_ce = 1'b0;
    logic [AW-1:0] hz_i_id_addr_rs1 = '0;
    logic [AW-1:0] hz_i_id_addr_rs2 = '0;
    logic          hz_i_ex_ce = 1'b0;
    logic          hz_i_ex_is_load = 1'b0;
    logic [AW-1:0] hz_i_ex_addr_rd = '0;
    logic          hz_i_change_pc = 1'b0;
    logic          hz_i_mem_req = 1'b0;
    logic          hz_i_mem_ack = 1'b0;
    logic          hz_o_stall_if;
    logic          hz_o_stall_id;
    logic          hz_o_stall_ex;
    logic          hz_o_flush_id;
    logic          hz_o_flush_ex;
    logic          hz_o_timeout;
    logic [1:0]    hz_o_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycles;
    logic [15:0]   flush_events;
`endif

    hazard_controller #(
        .AWIDTH(AW), .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT(MT), .CWIDTH(CW)
    ) dut (
        .hz_clk           (hz_clk),
        .hz_rst           (hz_rst),
        .hz_i_id_ce       (hz_i_id_ce),
        .hz_i_id_addr_rs1 (hz_i_id_addr_rs1),
        .hz_i_id_addr_rs2 (hz_i_id_addr_rs2),
        .hz_i_ex_ce       (hz_i_ex_ce),
        .hz_i_ex_is_load  (hz_i_ex_is_load),
        .hz_i_ex_addr_rd  (hz_i_ex_addr_rd),
        .hz_i_change_pc   (hz_i_change_pc),
        .hz_i_mem_req     (hz_i_mem_req),
        .hz_i_mem_ack     (hz_i_mem_ack),
        .hz_o_stall_if    (hz_o_stall_if),
        .hz_o_stall_id    (hz_o_stall_id),
        .hz_o_stall_ex    (hz_o_stall_ex),
        .hz_o_flush_id    (hz_o_flush_id),
        .hz_o_flush_ex    (hz_o_flush_ex),
        .hz_o_timeout     (hz_o_timeout),
        .hz_o_state       (hz_o_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .hz_o_stall_cycles(stall_cycles),
        .hz_o_flush_events(flush_events)
`endif
    );

    always #5 hz_clk = ~hz_clk;

    typedef struct packed {
        logic          id_ce;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          ex_ce;
        logic          is_load;
        logic [AW-1:0] rd;
        logic          cpc;
        logic          req;
        logic          ack;
    } in_t;

    typedef struct packed {
        logic       sif;
        logic       sid;
        logic       sex;
        logic       fid;
        logic       fex;
        logic       tmo;
        logic [1:0] st;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // model: 0 = running, 2 = memory wait, 3 = flushing front end
    int m_mode;
    bit m_lu;
    bit m_pend;
    bit m_tmo;
    int m_stalled;
    int m_flush_left;

    task automatic model_reset();
        m_mode = 0;
        m_lu = 0;
        m_pend = 0;
        m_tmo = 0;
        m_stalled = 0;
        m_flush_left = 0;
    endtask

    task automatic start_redirect(inout exp_t e);
        e.fid = 1;
        e.fex = 1;
        m_flush_left = FC - 1;
        m_mode = (m_flush_left > 0) ? 3 : 0;
    endtask

    task automatic model_step(input in_t v, output exp_t e);
        bit hit;
        bit mst;
        hit = v.ex_ce && v.is_load && (v.rd != 0) && v.id_ce
              && (v.rd == v.rs1 || v.rd == v.rs2);
        mst = v.req && !v.ack;
        e = '0;
        if (m_mode == 0) begin
            e.st = m_lu ? 2'd1 : 2'd0;
            m_lu = 0;
            if (v.cpc) begin
                start_redirect(e);
            end else if (mst) begin
                {e.sif, e.sid, e.sex} = 3'b111;
                m_mode = 2;
                m_stalled = 1;
            end else if (hit) begin
                {e.sif, e.sid, e.fex} = 3'b111;
                m_lu = 1;
            end
        end else if (m_mode == 2) begin
            e.st = 2'd2;
            if (v.ack) begin
                if (m_pend || v.cpc) start_redirect(e);
                else m_mode = 0;
                m_pend = 0;
            end else if (m_stalled == MT) begin
                m_tmo = 1;
                m_pend = 0;
                m_mode = 0;
            end else begin
                {e.sif, e.sid, e.sex} = 3'b111;
                m_stalled++;
                if (v.cpc) m_pend = 1;
            end
        end else begin
            e.st = 2'd3;
            e.fid = 1;
            if (v.cpc) begin
                start_redirect(e);
            end else begin
                m_flush_left--;
                if (m_flush_left == 0) m_mode = 0;
            end
        end
        e.tmo = m_tmo;
    endtask

    task automatic apply(input in_t v);
        hz_i_id_ce = v.id_ce;
        hz_i_id_addr_rs1 = v.rs1;
        hz_i_id_addr_rs2 = v.rs2;
        hz_i_ex_ce = v.ex_ce;
        hz_i_ex_is_load = v.is_load;
        hz_i_ex_addr_rd = v.rd;
        hz_i_change_pc = v.cpc;
        hz_i_mem_req = v.req;
        hz_i_mem_ack = v.ack;
    endtask

    task automatic step(input in_t v);
        exp_t e;
        @(posedge hz_clk);
        #1;
        apply(v);
        model_step(v, e);
        sb_q.push_back(e);
    endtask

    function automatic exp_t dut_out();
        exp_t g;
        g = {hz_o_stall_if, hz_o_stall_id, hz_o_stall_ex,
             hz_o_flush_id, hz_o_flush_ex, hz_o_timeout,
             hz_o_state};
        return g;
    endfunction

    // async reset dropped between edges with live inputs still applied
    task automatic do_reset();
        exp_t g;
        @(negedge hz_clk);
        #2;
        hz_rst = 1'b1;
        #1;
        g = dut_out();
        vectors++;
        if (g !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset t=%0t got=%b exp=%b",
                     $time, g, 8'h00);
        end
        model_reset();
        @(posedge hz_clk);
        #1;
        apply('0);
        hz_rst = 1'b0;
    endtask

    always @(negedge hz_clk) begin
        exp_t e;
        exp_t g;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            g = dut_out();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t got=%b exp=%b (sif sid sex fid fex tmo st)",
                         vectors, $time, g, e);
            end
        end
    end

    function automatic in_t rnd(input int ack_div);
        in_t v;
        v.id_ce = ($urandom % 4) != 0;
        v.rs1 = AW'($urandom % 4);
        v.rs2 = AW'($urandom % 4);
        v.ex_ce = ($urandom % 4) != 0;
        v.is_load = ($urandom % 2) != 0;
        v.rd = AW'($urandom % 4);
        v.cpc = ($urandom % 10) == 0;
        v.req = ($urandom % 4) == 0;
        v.ack = ($urandom % ack_div) == 0;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t queue=%0d", $time, sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        in_t z;
        in_t v;
        z = '0;
        model_reset();
        v = z;
        v.req = 1;
        v.cpc = 1;
        apply(v);
        do_reset();

        // load-use, then rd=0 variant
        v = z;
        v.ex_ce = 1;
        v.is_load = 1;
        v.rd = 5;
        v.id_ce = 1;
        v.rs2 = 5;
        step(v);
        step(z);
        step(z);
        v.rd = 0;
        v.rs2 = 0;
        step(v);
        step(z);

        // memory wait acked three cycles later, then same-cycle ack
        v = z;
        v.req = 1;
        repeat (3) step(v);
        v.ack = 1;
        step(v);
        step(z);
        step(v);
        step(z);

        // redirect and redirect colliding with load-use
        v = z;
        v.cpc = 1;
        step(v);
        step(z);
        step(z);
        v.ex_ce = 1;
        v.is_load = 1;
        v.rd = 3;
        v.id_ce = 1;
        v.rs1 = 3;
        step(v);
        step(z);
        step(z);

        // redirect while waiting on memory
        v = z;
        v.req = 1;
        step(v);
        v.cpc = 1;
        step(v);
        v.cpc = 0;
        step(v);
        v.ack = 1;
        step(v);
        repeat (3) step(z);

        // timeout with request held, reset lands mid-wait
        v = z;
        v.req = 1;
        repeat (18) step(v);
        step(z);
        do_reset();

        v = z;
        v.req = 1;
        repeat (3) step(v);
        do_reset();

        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 600; i++) begin
                step(rnd((blk % 2 == 0) ? 6 : 40));
            end
            do_reset();
        end

        @(posedge hz_clk);
        @(negedge hz_clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain queue=%0d exp=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Detects load-use hazards between decode and execute.
- Holds the pipeline while a load/store waits for the data memory, with a timeout.
- Sequences the multi-cycle front-end flush after execute signals a taken branch, jal or jalr.
- Drives the stall/flush inputs of the fetch, decode and execute stages.

Parameters:
AWIDTH, 5, register address width
FLUSH_CYCLES, 2, cycles decode stays flushed after a PC change (>=1)
MEM_TIMEOUT, 15, max MEM_WAIT cycles before abort (>=1)
CWIDTH, 4, width of the wait/flush counter (2^CWIDTH > MEM_TIMEOUT)

Ports:
hz_clk  input  1  clock, rising edge
hz_rst  input  1  asynchronous, active-high reset
hz_i_id_ce  input  1  decode holds a valid instruction
hz_i_id_addr_rs1  input  AWIDTH  decode rs1
hz_i_id_addr_rs2  input  AWIDTH  decode rs2
hz_i_ex_ce  input  1  execute holds a valid instruction
hz_i_ex_is_load  input  1  execute instruction is a load
hz_i_ex_addr_rd  input  AWIDTH  execute rd
hz_i_change_pc  input  1  execute redirect (taken branch/jal/jalr)
hz_i_mem_req  input  1  data-memory request issued this cycle
hz_i_mem_ack  input  1  data-memory completion
hz_o_stall_if  output  1  hold PC/fetch
hz_o_stall_id  output  1  hold decode register
hz_o_stall_ex  output  1  hold execute register
hz_o_flush_id  output  1  kill decode contents
hz_o_flush_ex  output  1  insert bubble into execute
hz_o_timeout  output  1  sticky memory-timeout error
hz_o_state  output  2  current FSM state (debug)

Behaviour:
- States (2-bit): IDLE=0, LOAD_USE=1, MEM_WAIT=2, FLUSH=3.
- Registers: state, counter cnt[CWIDTH], pend_redirect, timeout.
- Reset (hz_rst=1, asynchronous): state=IDLE, cnt=0, pend_redirect=0, timeout=0. All stall/flush outputs 0, hz_o_state=0.
- Outputs are Mealy, a combinational decode of state plus same-cycle inputs. A hazard seen in cycle N is acted on in cycle N. State updates on the rising edge.
- lu_hit = hz_i_ex_ce & hz_i_ex_is_load & (hz_i_ex_addr_rd!=0) & hz_i_id_ce & (rd==rs1 | rd==rs2).
- mem_stall = hz_i_mem_req & ~hz_i_mem_ack. A same-cycle request and ack never stalls.
- Priority in IDLE and LOAD_USE: change_pc > mem_stall > lu_hit.
- IDLE, on change_pc: flush_id=1, flush_ex=1. Go to FLUSH, cnt=FLUSH_CYCLES-1; if FLUSH_CYCLES=1, return to IDLE.
- IDLE, on mem_stall: stall_if=stall_id=stall_ex=1. Go to MEM_WAIT, cnt=1.
- IDLE, on lu_hit: stall_if=stall_id=1, flush_ex=1 (one bubble). Go to LOAD_USE.
- LOAD_USE: lasts exactly one cycle, no outputs unless a new event occurs. Events are evaluated with IDLE rules; otherwise return to IDLE. A second lu_hit here inserts a second bubble.
- MEM_WAIT: all three stalls held.
  - mem_ack: release stalls the same cycle. Go to FLUSH if pend_redirect (and clear it), else IDLE.
  - No ack and cnt==MEM_TIMEOUT: set timeout=1 (sticky until reset), release stalls, go to IDLE, clear pend_redirect.
  - Otherwise cnt++.
  - change_pc during MEM_WAIT sets pend_redirect. It does not flush until the wait exits.
- FLUSH: flush_id=1 each cycle. cnt-- and leave for IDLE when cnt==0. A new change_pc reloads cnt=FLUSH_CYCLES-1 and also pulses flush_ex. mem_req in FLUSH is honored as from IDLE after the flush ends.
- Stalls are never asserted in FLUSH. Flush and stall of the same stage are never asserted together.
- Counter arithmetic is unsigned and saturates at all-ones; it never wraps.
- Reset mid-MEM_WAIT aborts immediately; no timeout is recorded.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds hz_o_stall_cycles[31:0] (increments every cycle any stall output is 1) and hz_o_flush_events[15:0] (increments on each change_pc accepted or latched).
  - Both reset to 0 and wrap at max.
- Undefined: the ports are absent and no counter logic exists. Core behaviour is identical.

Decomposition:
- Shared header (header.vh) gets:
  - state encodings HZ_IDLE/HZ_LOAD_USE/HZ_MEM_WAIT/HZ_FLUSH;
  - HZ_STATE_WIDTH=2;
  - the existing LOAD_WORD/STORE_WORD opcode defines, used by the top level to derive hz_i_ex_is_load.
- One natural sub-module: hazard_detect, the combinational lu_hit comparator. Everything else lives in hazard_controller.

Test Plan:
- Load-use: ex load rd=5, id rs2=5 -> cycle N: stall_if=stall_id=flush_ex=1, state 0->1. Cycle N+1: all 0, then back to IDLE. Same stimulus with rd=0 -> no stall.
- Mem wait: mem_req=1 at cycle N, ack at N+3 -> stall_* high in cycles N..N+2, low at N+3, state IDLE at N+4. Same-cycle req+ack -> no stall.
- Timeout: MEM_TIMEOUT=15, req with no ack -> stalls held 15 cycles, timeout=1 on release and stays 1 until hz_rst.
- Redirect: change_pc at N with FLUSH_CYCLES=2 -> flush_ex high at N; flush_id high at N, N+1; state 3 at N+1, IDLE at N+2.
- Collisions:
  - change_pc during MEM_WAIT, ack 2 cycles later -> no flush until the ack cycle, then FLUSH.
  - change_pc and lu_hit together -> flush wins, no stall.
- Async reset asserted mid-MEM_WAIT, between clock edges -> all outputs 0 immediately, state 0, timeout 0.
